pu_array_datapath: RTL and testbench

Four-lane processing-unit datapath driven by the `Controller` FSM; it is the responder that consumes the controller's enable/select strobes and returns the status inputs `z0`–`z3` and `end_signal`. Each lane holds an A operand register, a B operand register, a multiply pipeline register and an accumulator. On `done`, the lane selected by `res_mux` is captured to a result port and the accumulators are cleared for the next frame.

---
 rtl/pu_array_datapath.sv | 85 ++++++++
 tb/tb_pu_array_datapath.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pu_array_datapath.sv
// Four-lane multiply-accumulate datapath that responds to the Controller FSM strobes.
// Each lane is a 3-stage pipeline: operand registers -> product register -> accumulator.
module pu_array_datapath #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH+4,
    parameter int COUNT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] a_in,
    input  logic [4*WIDTH-1:0] b_in,
    input  logic               a_regs_en,
    input  logic               a_muxs,
    input  logic               b_regs_en,
    input  logic               pu_mult_regs_en,
    input  logic               pu_add_regs_en,
    input  logic [1:0]         res_mux,
    input  logic               done,
    output logic [ACC_W-1:0]   result,
    output logic               result_valid,
    output logic               z0,
    output logic               z1,
    output logic               z2,
    output logic               z3,
    output logic               end_signal
);

    localparam int CNT_W = $clog2(COUNT+1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT);

    logic signed [WIDTH-1:0]   a_reg [4];
    logic signed [WIDTH-1:0]   b_reg [4];
    logic signed [2*WIDTH-1:0] m_reg [4];
    logic signed [ACC_W-1:0]   acc   [4];
    logic [CNT_W-1:0]          cnt;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        localparam int NEXT = (i + 1) % 4;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
                m_reg[i] <= '0;
                acc[i]   <= '0;
            end else begin
                // Rotation reads the neighbour's pre-edge value, so all lanes shift together.
                if (a_regs_en)
                    a_reg[i] <= a_muxs ? a_reg[NEXT] : a_in[i*WIDTH +: WIDTH];
                if (b_regs_en)
                    b_reg[i] <= b_in[i*WIDTH +: WIDTH];
                if (pu_mult_regs_en)
                    m_reg[i] <= (2*WIDTH)'(a_reg[i]) * (2*WIDTH)'(b_reg[i]);
                // Frame clear takes priority over a same-cycle accumulate.
                if (done)
                    acc[i] <= '0;
                else if (pu_add_regs_en)
                    acc[i] <= acc[i] + ACC_W'(m_reg[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= done;
            if (done) begin
                result <= acc[res_mux];
                cnt    <= '0;
            end else if (pu_add_regs_en && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign z0         = (acc[0] == '0);
    assign z1         = (acc[1] == '0);
    assign z2         = (acc[2] == '0);
    assign z3         = (acc[3] == '0);
    assign end_signal = (cnt == CNT_MAX);

endmodule

// File: tb/tb_pu_array_datapath.sv
// Self-checking bench for pu_array_datapath: table-driven frames plus hand-written
// multi-cycle sequences; captured results are checked through a scoreboard queue.
module tb_pu_array_datapath;

    localparam int WIDTH = 8;
    localparam int ACC_W = 2*WIDTH+4;
    localparam int COUNT = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [4*WIDTH-1:0] a_in;
    logic [4*WIDTH-1:0] b_in;
    logic               a_regs_en;
    logic               a_muxs;
    logic               b_regs_en;
    logic               pu_mult_regs_en;
    logic               pu_add_regs_en;
    logic [1:0]         res_mux;
    logic               done;
    logic [ACC_W-1:0]   result;
    logic               result_valid;
    logic               z0, z1, z2, z3;
    logic               end_signal;

    int total = 0;
    int bad   = 0;
    logic signed [ACC_W-1:0] sb [$];

    pu_array_datapath #(.WIDTH(WIDTH), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .a_regs_en(a_regs_en), .a_muxs(a_muxs), .b_regs_en(b_regs_en),
        .pu_mult_regs_en(pu_mult_regs_en), .pu_add_regs_en(pu_add_regs_en),
        .res_mux(res_mux), .done(done), .result(result), .result_valid(result_valid),
        .z0(z0), .z1(z1), .z2(z2), .z3(z3), .end_signal(end_signal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*WIDTH-1:0]      a;
        logic [4*WIDTH-1:0]      b;
        logic [1:0]              sel;
        logic signed [ACC_W-1:0] exp_res;
        logic [3:0]              exp_z;
    } vec_t;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle of control strobes; a done strobe queues its expected result.
    task automatic applyStimulus(input logic ae, input logic am, input logic be,
                                 input logic me, input logic ad, input logic dn,
                                 input logic [1:0] sel, input logic signed [ACC_W-1:0] exp_res);
        a_regs_en       = ae;
        a_muxs          = am;
        b_regs_en       = be;
        pu_mult_regs_en = me;
        pu_add_regs_en  = ad;
        done            = dn;
        res_mux         = sel;
        if (dn && !rst) sb.push_back(exp_res);
        @(posedge clk);
        #1;
        a_regs_en = 0; a_muxs = 0; b_regs_en = 0;
        pu_mult_regs_en = 0; pu_add_regs_en = 0; done = 0; res_mux = 0;
    endtask

    function automatic longint zvec();
        return longint'({z3, z2, z1, z0});
    endfunction

    // Scoreboard side: each result_valid pulse must match the oldest queued done.
    always @(negedge clk) begin
        if (result_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result_valid", 1, 0);
            end else begin
                checkOutput("result", longint'($signed(result)), longint'(sb.pop_front()));
            end
        end
    end

    vec_t vecs [5];

    initial begin
        vecs[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1},    b: {8'd2, 8'd2, 8'd2, 8'd2},
                    sel: 2'd2, exp_res: 20'sd6,      exp_z: 4'b0000};
        vecs[1] = '{a: {8'h80, 8'd7, 8'd5, 8'hFD},  b: {8'h80, 8'd5, 8'd5, 8'd5},
                    sel: 2'd3, exp_res: 20'sd16384,  exp_z: 4'b0000};
        vecs[2] = '{a: {8'hFF, 8'd10, 8'd0, 8'hFD}, b: {8'hFF, 8'hF6, 8'd9, 8'd5},
                    sel: 2'd0, exp_res: -20'sd15,    exp_z: 4'b0010};
        vecs[3] = '{a: {8'd2, 8'd0, 8'h80, 8'h7F},  b: {8'd3, 8'd3, 8'h7F, 8'h7F},
                    sel: 2'd1, exp_res: -20'sd16256, exp_z: 4'b0100};
        vecs[4] = '{a: {8'd4, 8'd4, 8'd4, 8'd4},    b: {8'd6, 8'hFF, 8'd1, 8'd0},
                    sel: 2'd0, exp_res: 20'sd0,      exp_z: 4'b0001};

        // Reset held with every strobe asserted.
        rst = 1; a_in = '1; b_in = '1;
        a_regs_en = 1; a_muxs = 1; b_regs_en = 1; pu_mult_regs_en = 1;
        pu_add_regs_en = 1; done = 1; res_mux = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_result", longint'(result), 0);
        checkOutput("reset_valid", longint'(result_valid), 0);
        checkOutput("reset_end", longint'(end_signal), 0);
        checkOutput("reset_z", zvec(), 4'b1111);
        rst = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            a_in = vecs[i].a;
            b_in = vecs[i].b;
            applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("vec%0d_z", i), zvec(), longint'(vecs[i].exp_z));
            applyStimulus(0, 0, 0, 0, 0, 1, vecs[i].sel, vecs[i].exp_res);
            checkOutput($sformatf("vec%0d_z_cleared", i), zvec(), 4'b1111);
        end

        // Rotate: a={1,2,3,4} -> {2,3,4,1} -> {3,4,1,2}, b all 1.
        a_in = {8'd4, 8'd3, 8'd2, 8'd1};
        b_in = {8'd1, 8'd1, 8'd1, 8'd1};
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 20'sd2);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 20'sd3);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'd3, 20'sd2);
        // a_muxs alone must not rotate.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 20'sd3);

        // Signed lane 0: -3*5 accumulated twice, then +15*2 returns to zero.
        a_in = {8'd0, 8'd0, 8'd0, 8'hFD};
        b_in = {8'd0, 8'd0, 8'd0, 8'd5};
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("signed_z0_after_first_add", longint'(z0), 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        a_in = {8'd0, 8'd0, 8'd0, 8'd15};
        b_in = {8'd0, 8'd0, 8'd0, 8'd2};
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("signed_z0_back_to_zero", longint'(z0), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 20'sd0);

        // Counter: m0 = 30, five strobes saturate the counter while acc keeps growing.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("end_after_add%0d", k), longint'(end_signal), (k >= COUNT) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 20'sd150);
        checkOutput("end_after_done", longint'(end_signal), 0);

        // Collision: done together with add on acc1=7, m1=3.
        a_in = {8'd0, 8'd0, 8'd7, 8'd0};
        b_in = {8'd0, 8'd0, 8'd1, 8'd0};
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        a_in = {8'd0, 8'd0, 8'd3, 8'd0};
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 2'd1, 20'sd7);
        checkOutput("collision_z1", longint'(z1), 1);
        checkOutput("collision_end", longint'(end_signal), 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("collision_cnt_three", longint'(end_signal), 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("collision_cnt_four", longint'(end_signal), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'd1, 20'sd12);

        // Reset mid-frame wipes operands, products, accumulators and the result.
        a_in = {8'd1, 8'd1, 8'd1, 8'd1};
        b_in = {8'd1, 8'd1, 8'd1, 8'd1};
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("pre_reset_z", zvec(), 4'b0000);
        rst = 1;
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        rst = 0;
        checkOutput("midreset_z", zvec(), 4'b1111);
        checkOutput("midreset_end", longint'(end_signal), 0);
        checkOutput("midreset_result", longint'(result), 0);
        checkOutput("midreset_valid", longint'(result_valid), 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("post_reset_z", zvec(), 4'b1111);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'd0, 20'sd0);

        for (int w = 0; w < 5 && sb.size() != 0; w++) @(posedge clk);
        checkOutput("scoreboard_drained", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
